// File: rtl/mem2axi_if.sv
// mem2axi_if: memory-request bundle and single-beat AXI4 master bundle for mem2axi.
interface mem2axi_mem_if;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [31:0] addr_i;
  logic [7:0]  be_i;
  logic [63:0] data_i;
  logic        rvalid_o;
  logic [63:0] rdata_o;
  logic        err_o;
  modport slave (input req_i, we_i, addr_i, be_i, data_i, output gnt_o, rvalid_o, rdata_o, err_o);
  modport master (output req_i, we_i, addr_i, be_i, data_i, input gnt_o, rvalid_o, rdata_o, err_o);
endinterface

interface mem2axi_axi_if #(parameter int AXI_ID_WIDTH = 3);
  logic                    aw_valid_o;
  logic                    aw_ready_i;
  logic [AXI_ID_WIDTH-1:0] aw_id_o;
  logic [31:0]             aw_addr_o;
  logic [7:0]              aw_len_o;
  logic [2:0]              aw_size_o;
  logic [1:0]              aw_burst_o;
  logic                    w_valid_o;
  logic                    w_ready_i;
  logic [63:0]             w_data_o;
  logic [7:0]              w_strb_o;
  logic                    w_last_o;
  logic                    b_valid_i;
  logic                    b_ready_o;
  logic [AXI_ID_WIDTH-1:0] b_id_i;
  logic [1:0]              b_resp_i;
  logic                    ar_valid_o;
  logic                    ar_ready_i;
  logic [AXI_ID_WIDTH-1:0] ar_id_o;
  logic [31:0]             ar_addr_o;
  logic [7:0]              ar_len_o;
  logic [2:0]              ar_size_o;
  logic [1:0]              ar_burst_o;
  logic                    r_valid_i;
  logic                    r_ready_o;
  logic [AXI_ID_WIDTH-1:0] r_id_i;
  logic [63:0]             r_data_i;
  logic [1:0]              r_resp_i;
  logic                    r_last_i;
  modport master (
    output aw_valid_o, aw_id_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o,
    output w_valid_o, w_data_o, w_strb_o, w_last_o, b_ready_o,
    output ar_valid_o, ar_id_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, r_ready_o,
    input  aw_ready_i, w_ready_i, b_valid_i, b_id_i, b_resp_i,
    input  ar_ready_i, r_valid_i, r_id_i, r_data_i, r_resp_i, r_last_i
  );
  modport slave (
    input  aw_valid_o, aw_id_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o,
    input  w_valid_o, w_data_o, w_strb_o, w_last_o, b_ready_o,
    input  ar_valid_o, ar_id_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, r_ready_o,
    output aw_ready_i, w_ready_i, b_valid_i, b_id_i, b_resp_i,
    output ar_ready_i, r_valid_i, r_id_i, r_data_i, r_resp_i, r_last_i
  );
endinterface

// File: rtl/mem2axi.sv
// mem2axi: bridges a one-outstanding memory request port onto single-beat 64-bit AXI4 transfers.
module mem2axi #(
  parameter int AXI_ID_WIDTH = 3,
  parameter int AXI_ID       = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mem2axi_mem_if.slave  mem,
  mem2axi_axi_if.master axi
);
  localparam logic [AXI_ID_WIDTH-1:0] ID = AXI_ID_WIDTH'(AXI_ID);
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;
  state_t state, state_nx;
  logic [31:3] addr_q;
  logic [7:0]  be_q;
  logic [63:0] data_q, rdata_q;
  logic        we_q, aw_done, w_done, bad_beat, rvalid_q, err_q;
  logic        gnt, aw_hs, w_hs, b_hs, r_hs, r_end, done, err_nx;
  assign gnt            = mem.req_i & rst_ni & (state == IDLE);
  assign mem.gnt_o      = gnt;
  assign mem.rvalid_o   = rvalid_q;
  assign mem.err_o      = err_q;
  assign mem.rdata_o    = rdata_q;
  assign axi.aw_valid_o = (state == WADDR) & ~aw_done;
  assign axi.w_valid_o  = (state == WADDR) & ~w_done;
  assign axi.b_ready_o  = state == WRESP;
  assign axi.ar_valid_o = state == RADDR;
  assign axi.r_ready_o  = state == RDATA;
  assign axi.aw_id_o    = ID;
  assign axi.ar_id_o    = ID;
  assign axi.aw_addr_o  = {addr_q, 3'b000};
  assign axi.ar_addr_o  = {addr_q, 3'b000};
  assign axi.aw_len_o   = 8'd0;
  assign axi.ar_len_o   = 8'd0;
  assign axi.aw_size_o  = 3'd3;
  assign axi.ar_size_o  = 3'd3;
  assign axi.aw_burst_o = 2'b01;
  assign axi.ar_burst_o = 2'b01;
  assign axi.w_data_o   = data_q;
  assign axi.w_strb_o   = be_q;
  assign axi.w_last_o   = 1'b1;
  assign aw_hs  = axi.aw_valid_o & axi.aw_ready_i;
  assign w_hs   = axi.w_valid_o & axi.w_ready_i;
  assign b_hs   = axi.b_ready_o & axi.b_valid_i;
  assign r_hs   = axi.r_ready_o & axi.r_valid_i;
  assign r_end  = r_hs & axi.r_last_i;
  assign done   = b_hs | r_end;
  // a stray non-last read beat taints the eventual completion
  assign err_nx = we_q ? ((axi.b_resp_i != 2'b00) | (axi.b_id_i != ID))
                       : ((axi.r_resp_i != 2'b00) | (axi.r_id_i != ID) | bad_beat);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = gnt ? (mem.we_i ? WADDR : RADDR) : IDLE;
      WADDR:   state_nx = ((aw_done | aw_hs) & (w_done | w_hs)) ? WRESP : WADDR;
      WRESP:   state_nx = axi.b_valid_i ? IDLE : WRESP;
      RADDR:   state_nx = axi.ar_ready_i ? RDATA : RADDR;
      RDATA:   state_nx = r_end ? IDLE : RDATA;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      bad_beat <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state    <= state_nx;
      rvalid_q <= done;
      err_q    <= done & err_nx;
      if (gnt) begin
        addr_q   <= mem.addr_i[31:3];
        be_q     <= mem.be_i;
        data_q   <= mem.data_i;
        we_q     <= mem.we_i;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
        bad_beat <= 1'b0;
      end else begin
        aw_done  <= aw_done | aw_hs;
        w_done   <= w_done | w_hs;
        bad_beat <= bad_beat | (r_hs & ~axi.r_last_i);
      end
      if (r_end) rdata_q <= axi.r_data_i;
    end
  end
endmodule
